// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the CPU data-port memory responder.
package data_mem_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = NUM_LANES * BYTE_W;

  // Replace the strobed byte lanes of old_word with those of new_word.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0]    old_word,
    input logic [WORD_W-1:0]    new_word,
    input logic [NUM_LANES-1:0] strb
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (strb[l]) begin
        merged[l*BYTE_W +: BYTE_W] = new_word[l*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_sram.sv
// Word-addressed storage with per-lane write enables and combinational read.
module dm_sram_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned AddrBits = 12
) (
  input  logic                 clk_i,
  input  logic [NUM_LANES-1:0] we_i,
  input  logic [AddrBits-1:0]  waddr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic [AddrBits-1:0]  raddr_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem_q [2**AddrBits];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we_i[l]) begin
        mem_q[waddr_i][l*BYTE_W +: BYTE_W] <= wdata_i[l*BYTE_W +: BYTE_W];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: post-reset clear, range check, registered read.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned AddrBits     = 12,
  parameter int unsigned DataWidth    = 32,
  parameter bit          ClearOnReset = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_read,
  input  logic [NUM_LANES-1:0] data_write,
  input  logic [31:0]          data_addr,
  input  logic [DataWidth-1:0] data_in,
  output logic [DataWidth-1:0] data_out,
  output logic                 ready,
  output logic                 addr_err,
  output logic                 clear_done
);

  localparam state_e RstState = ClearOnReset ? ST_CLEAR : ST_READY;

  state_e                state_q, state_d;
  logic [AddrBits-1:0]   clear_cnt_q, clear_cnt_d;
  logic [DataWidth-1:0]  data_out_q, data_out_d;
  logic                  ready_q, ready_d;
  logic                  addr_err_q, addr_err_d;
  logic                  clear_done_q, clear_done_d;

  logic [AddrBits-1:0]   idx;
  logic                  in_range;
  logic                  access;
  logic [NUM_LANES-1:0]  mem_we;
  logic [AddrBits-1:0]   mem_waddr;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  unused_addr_lsbs;

  assign idx              = data_addr[AddrBits+1:2];
  assign in_range         = (data_addr[31:AddrBits+2] == '0);
  assign access           = data_read || (data_write != '0);
  assign unused_addr_lsbs = ^data_addr[1:0];

  dm_sram_array #(
    .AddrBits(AddrBits)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(idx),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    clear_cnt_d  = clear_cnt_q;
    data_out_d   = data_out_q;
    ready_d      = ready_q;
    addr_err_d   = 1'b0;
    clear_done_d = clear_done_q;
    mem_we       = '0;
    mem_waddr    = idx;
    mem_wdata    = data_in;

    unique case (state_q)
      ST_CLEAR: begin
        // User traffic is ignored while the array is being zeroed.
        mem_we      = '1;
        mem_waddr   = clear_cnt_q;
        mem_wdata   = '0;
        clear_cnt_d = clear_cnt_q + AddrBits'(1);
        if (clear_cnt_q == {AddrBits{1'b1}}) begin
          state_d      = ST_READY;
          ready_d      = 1'b1;
          clear_done_d = 1'b1;
        end
      end
      ST_READY: begin
        ready_d    = 1'b1;
        addr_err_d = access && !in_range;
        if (in_range) begin
          mem_we = data_write;
        end
        // Write-first: a same-cycle read sees the freshly strobed lanes.
        if (data_read) begin
          data_out_d = in_range ? merge_bytes(mem_rdata, data_in, data_write) : '0;
        end
      end
      default: state_d = RstState;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RstState;
      clear_cnt_q  <= '0;
      data_out_q   <= '0;
      ready_q      <= 1'b0;
      addr_err_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      data_out_q   <= data_out_d;
      ready_q      <= ready_d;
      addr_err_q   <= addr_err_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign ready      = ready_q;
  assign addr_err   = addr_err_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed check of data_mem_responder against a behavioural model.
module tb_data_mem_responder;

  localparam int Depth = 16;

  logic        clk;
  logic        rst;
  logic        data_read;
  logic [3:0]  data_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        addr_err;
  logic        clear_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: memory image, edges seen since reset, expected outputs.
  logic [31:0] m_mem [Depth];
  int          m_edges;
  logic [31:0] m_dout;
  logic        m_err;
  logic        m_ready;
  logic        m_done;

  data_mem_responder #(
    .AddrBits    (4),
    .DataWidth   (32),
    .ClearOnReset(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_read (data_read),
    .data_write(data_write),
    .data_addr (data_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .ready     (ready),
    .addr_err  (addr_err),
    .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] w;
    int          wi;
    if (m_edges < Depth) begin
      m_edges++;
      m_err = 1'b0;
      if (m_edges == Depth) begin
        for (int i = 0; i < Depth; i++) m_mem[i] = 32'h0;
        m_ready = 1'b1;
        m_done  = 1'b1;
      end
    end else begin
      m_err = (data_read || data_write != 4'h0) && (data_addr >= 32'd64);
      if (data_addr < 32'd64) begin
        wi = int'(data_addr / 4);
        w  = m_mem[wi];
        for (int b = 0; b < 4; b++) begin
          if (data_write[b]) w[b*8 +: 8] = data_in[b*8 +: 8];
        end
        m_mem[wi] = w;
        if (data_read) m_dout = w;
      end else if (data_read) begin
        m_dout = 32'h0;
      end
    end
  endtask

  task automatic step(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                      input logic [31:0] din);
    data_read  = rd;
    data_write = wr;
    data_addr  = addr;
    data_in    = din;
    @(posedge clk);
    model_edge();
    #1;
    check("data_out", data_out, m_dout);
    check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    check("ready", {31'b0, ready}, {31'b0, m_ready});
    check("clear_done", {31'b0, clear_done}, {31'b0, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic do_reset();
    data_read  = 1'b0;
    data_write = 4'h0;
    data_addr  = 32'h0;
    data_in    = 32'h0;
    rst = 1'b1;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_addr_err", {31'b0, addr_err}, 32'h0);
    check("rst_clear_done", {31'b0, clear_done}, 32'h0);
    m_edges = 0;
    m_dout  = 32'h0;
    m_err   = 1'b0;
    m_ready = 1'b0;
    m_done  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    rst        = 1'b0;
    data_read  = 1'b0;
    data_write = 4'h0;
    data_addr  = 32'h0;
    data_in    = 32'h0;
    #2;

    // Reset then clear; ready/clear_done rise on exactly the 16th edge.
    do_reset();
    idle(15);
    check("t1_not_ready_15", {31'b0, ready}, 32'h0);
    idle(1);
    check("t1_ready_16", {31'b0, ready}, 32'h1);
    check("t1_done_16", {31'b0, clear_done}, 32'h1);
    step(1'b1, 4'h0, 32'h3C, 32'h0);
    check("t1_rd_3c", data_out, 32'h0);

    // Full write then partial write.
    step(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
    step(1'b1, 4'h0, 32'h10, 32'h0);
    check("t2_rd_full", data_out, 32'hDEADBEEF);
    step(1'b0, 4'h1, 32'h10, 32'h000000AA);
    step(1'b1, 4'h0, 32'h10, 32'h0);
    check("t2_rd_lane0", data_out, 32'hDEADBEAA);

    // Same-cycle write and read is write-first.
    step(1'b0, 4'hF, 32'h20, 32'hAAAAAAAA);
    step(1'b1, 4'hC, 32'h20, 32'h12345678);
    check("t3_rdw", data_out, 32'h1234AAAA);

    // Out-of-range write and read.
    step(1'b0, 4'hF, 32'h0, 32'h5A5A5A5A);
    step(1'b0, 4'hF, 32'h40, 32'hFFFFFFFF);
    check("t4_err_wr", {31'b0, addr_err}, 32'h1);
    step(1'b1, 4'h0, 32'h0, 32'h0);
    check("t4_err_clear", {31'b0, addr_err}, 32'h0);
    check("t4_word0", data_out, 32'h5A5A5A5A);
    step(1'b1, 4'h0, 32'h40, 32'h0);
    check("t4_err_rd", {31'b0, addr_err}, 32'h1);
    check("t4_rd_zero", data_out, 32'h0);
    step(1'b1, 4'h0, 32'h44, 32'h0);
    step(1'b0, 4'h2, 32'h8000_0000, 32'h0);
    check("t4_err_b2b", {31'b0, addr_err}, 32'h1);
    idle(1);

    // Async reset while data_out is nonzero, then access during clear.
    step(1'b1, 4'h0, 32'h0, 32'h0);
    do_reset();
    idle(4);
    step(1'b1, 4'hF, 32'h10, 32'hFFFFFFFF);
    check("t5_dout_clear", data_out, 32'h0);
    check("t5_err_clear", {31'b0, addr_err}, 32'h0);
    idle(11);
    step(1'b1, 4'h0, 32'h10, 32'h0);
    check("t5_post_clear", data_out, 32'h0);

    // Reset at clear cycle 7; full clear must rerun.
    do_reset();
    idle(7);
    do_reset();
    idle(15);
    check("t6_not_ready_15", {31'b0, ready}, 32'h0);
    idle(1);
    check("t6_ready_16", {31'b0, ready}, 32'h1);

    // Random traffic, with one mid-stream reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h40;
      else addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      step(rd, wr, addr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
